dcache_flush_engine: RTL
========================

# dcache_flush_engine

Cache-side responder for the data-cache control handshake. It accepts `dcache_flush` and `dcache_clear` requests from the pipeline and walks every frame of the set-associative D-cache. For a flush, dirty blocks are written back to memory over a word-wide write port. The engine then invalidates each frame and reports completion on `dflush_done` / `dclear_done`. It sits inside the D-cache, between the cache-control handshake, the tag/data arrays and the cache's bus-side write port.

## Interface
- `NSETS`, 32, number of sets; power of 2, ≥2
- `NWAYS`, 2, ways per set; power of 2, ≥1
- `WORDS_PER_BLOCK`, 2, 32-bit words per block; power of 2, ≥1
- `CLK`  in  1  clock; all state changes on the rising edge
- `nRST`  in  1  reset, synchronous, active-low
- `dcache_flush`  in  1  flush request (write back dirty blocks, then invalidate); level, held until done
- `dcache_clear`  in  1  clear request (invalidate all, no write-back); level, held until done
- `dflush_done`  out  1  flush complete; held high while `dcache_flush` stays high
- `dclear_done`  out  1  clear complete; held high while `dcache_clear` stays high
- `engine_busy`  out  1  high in every non-IDLE state; the cache stalls normal hits/misses while high
- `arr_set`  out  log2(NSETS)  set index driven to the tag/data arrays
- `arr_way`  out  log2(NWAYS)  way index
- `arr_word`  out  log2(WORDS_PER_BLOCK)  word index for the data-array read
- `arr_valid`, `arr_dirty`  in  1 each  frame status, valid one cycle after index
- `arr_tag`  in  32−log2(NSETS)−log2(WORDS_PER_BLOCK)−2  frame tag, one-cycle latency
- `arr_rdata`  in  32  data word, one-cycle latency
- `arr_inval`  out  1  one-cycle strobe; clears valid and dirty of frame (`arr_set`, `arr_way`)
- `mem_wen`  out  1  memory write request
- `mem_addr`  out  32  byte address
- `mem_wdata`  out  32  write data
- `mem_busy`  in  1  low in a cycle with `mem_wen` high means the word is accepted that cycle

## Operation
- States: IDLE, READ_TAG, CHECK, WB_REQ, WB_WAIT, INVAL, DONE.
- IDLE, either request high:
  - latch the operation: flush if `dcache_flush` is high, else clear;
  - set = 0, way = 0; go to READ_TAG.
- READ_TAG: drive indices, word = 0 → CHECK.
- CHECK: if the operation is a flush and `arr_valid & arr_dirty` → WB_REQ, else → INVAL.
- WB_REQ: drive `arr_word` = word → WB_WAIT.
- WB_WAIT: drive the write.
  - `mem_wen` = 1, `mem_addr` = {tag, set, word, 2'b00}, `mem_wdata` = `arr_rdata` (registered).
  - Hold until `mem_busy` = 0.
  - Then, if this is the last word → INVAL; else word+1 → WB_REQ.
- INVAL: `arr_inval` = 1 for one cycle.
  - Advance way; when way wraps, advance set.
  - If the last set and way are done → DONE, else → READ_TAG.
  - Order is set-major, way-minor.
- DONE: `dflush_done` = `dcache_flush`, `dclear_done` = `dcache_clear` (combinational from the inputs).
  - Return to IDLE when both requests are low.
- Both requests high at start: a flush is performed, and both done signals assert (flush subsumes clear).
- A request dropped mid-walk is ignored; the walk completes. DONE then asserts nothing and exits the next cycle.
- Clear writes nothing to memory, including dirty lines; their data is discarded.
- `nRST` low, including mid-walk: next edge returns to IDLE. All outputs reset to 0, indices reset to 0, the walk is abandoned.

## Timing
- Request sampled in IDLE at cycle 0; first READ_TAG in cycle 1.
- Clean or skipped frame: 3 cycles.
- Dirty frame under flush: 3 + 2·WORDS_PER_BLOCK cycles with zero wait states, plus one cycle per `mem_busy` stall.
- Clear latency with defaults: DONE entered at cycle 1 + 3·64 = 193; done visible in that cycle.
- `mem_addr` and `mem_wdata` stay stable while `mem_wen` is high and `mem_busy` is high.

## Configuration
- `DCACHE_FLUSH_PERF_EN` defined:
  - adds output `wb_count` (16 bits), the number of words written back in the most recent operation;
  - cleared on leaving IDLE, incremented on each accepted word, saturates at 0xFFFF.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

## Structure
- Package `dcache_flush_pkg`:
  - state enum `flush_state_t`;
  - operation enum (FLUSH/CLEAR);
  - address-packing function taking tag, set and word.
- One sub-module, `flush_frame_walker`:
  - set/way/word counters with wrap and last-frame flags;
  - reset to 0 on `nRST` or when a walk starts.

## Test plan
- Clear, all 64 frames valid and dirty → no `mem_wen`, 64 `arr_inval` pulses, `dclear_done` at cycle 193.
- Flush, only set 5 way 1 dirty, tag 0x1234 → two writes at {0x1234, 5, word 0/1, 00} with array data, then `dflush_done`.
- Flush with `mem_busy` held 4 cycles on the first word → `mem_addr`/`mem_wdata` stable; total latency +4.
- Both requests high → flush performed, both done signals high; dropping `dcache_clear` drops only `dclear_done`.
- `nRST` low during WB_WAIT → IDLE, `mem_wen` = 0; a new flush restarts at set 0, way 0.
- With `DCACHE_FLUSH_PERF_EN`, 3 dirty frames → `wb_count` = 6.

Source files
------------

// File: rtl/dcache_flush_pkg.sv
// Shared types and helpers for the D-cache flush/clear engine.
// Optional build macro used by the engine: DCACHE_FLUSH_PERF_EN (write-back word counter).
package dcache_flush_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ_TAG,
      ST_CHECK,
      ST_WB_REQ,
      ST_WB_WAIT,
      ST_INVAL,
      ST_DONE
   } flush_state_t;

   typedef enum logic {
      OP_CLEAR,
      OP_FLUSH
   } flush_op_t;

   localparam int WORD_BYTE_BITS = 2;

   // Byte address of a cached word: {tag, set, word, 2'b00}.
   function automatic logic [31:0] pack_addr(input logic [31:0] tag,
                                             input logic [31:0] set,
                                             input logic [31:0] word,
                                             input int          set_bits,
                                             input int          word_bits);
      return (tag << (set_bits + word_bits + WORD_BYTE_BITS))
           | (set << (word_bits + WORD_BYTE_BITS))
           | (word << WORD_BYTE_BITS);
   endfunction

endpackage

// File: rtl/flush_frame_walker.sv
// Set/way/word index counters for the flush walk (set-major, way-minor).
module flush_frame_walker #(
   parameter int NSETS           = 32,
   parameter int NWAYS           = 2,
   parameter int WORDS_PER_BLOCK = 2,
   parameter int SET_W           = 5,
   parameter int WAY_W           = 1,
   parameter int WORD_W          = 1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              start_i,
   input  logic              frame_adv_i,
   input  logic              word_clr_i,
   input  logic              word_adv_i,
   output logic [SET_W-1:0]  set_o,
   output logic [WAY_W-1:0]  way_o,
   output logic [WORD_W-1:0] word_o,
   output logic              last_frame_o,
   output logic              last_word_o
);

   logic [SET_W-1:0]  set_q;
   logic [WAY_W-1:0]  way_q;
   logic [WORD_W-1:0] word_q;
   logic              last_way;
   logic              last_set;

   assign last_way     = (way_q == WAY_W'(NWAYS - 1));
   assign last_set     = (set_q == SET_W'(NSETS - 1));
   assign last_frame_o = last_way & last_set;
   assign last_word_o  = (word_q == WORD_W'(WORDS_PER_BLOCK - 1));
   assign set_o        = set_q;
   assign way_o        = way_q;
   assign word_o       = word_q;

   // Way advances per frame; set advances when way wraps. Set wraps to 0 after the last frame.
   always_ff @(posedge CLK) begin
      if (!nRST || start_i) begin
         set_q  <= '0;
         way_q  <= '0;
         word_q <= '0;
      end else begin
         if (frame_adv_i) begin
            if (last_way) begin
               way_q <= '0;
               set_q <= set_q + SET_W'(1);
            end else begin
               way_q <= way_q + WAY_W'(1);
            end
         end
         if (word_clr_i) begin
            word_q <= '0;
         end else if (word_adv_i) begin
            word_q <= word_q + WORD_W'(1);
         end
      end
   end

endmodule

// File: rtl/dcache_flush_engine.sv
// D-cache flush/clear engine: walks every frame, writes back dirty blocks on flush,
// invalidates each frame and reports completion. Optional macro DCACHE_FLUSH_PERF_EN
// adds the wb_count output (words written back by the most recent operation).
//
// state      | meaning
// IDLE       | waiting for a flush or clear request
// READ_TAG   | frame indices driven to the arrays
// CHECK      | frame status returned; decide write-back or invalidate
// WB_REQ     | data-array word index driven
// WB_WAIT    | memory write held until accepted (mem_busy low)
// INVAL      | one-cycle invalidate strobe, advance to next frame
// DONE       | completion reported until both requests drop
module dcache_flush_engine
   import dcache_flush_pkg::*;
#(
   parameter int NSETS           = 32,
   parameter int NWAYS           = 2,
   parameter int WORDS_PER_BLOCK = 2,
   localparam int SET_W    = $clog2(NSETS),
   localparam int WAY_W    = (NWAYS > 1) ? $clog2(NWAYS) : 1,
   localparam int WORD_LOG = $clog2(WORDS_PER_BLOCK),
   localparam int WORD_W   = (WORD_LOG > 0) ? WORD_LOG : 1,
   localparam int TAG_W    = 32 - SET_W - WORD_LOG - 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              dcache_flush,
   input  logic              dcache_clear,
   output logic              dflush_done,
   output logic              dclear_done,
   output logic              engine_busy,
   output logic [SET_W-1:0]  arr_set,
   output logic [WAY_W-1:0]  arr_way,
   output logic [WORD_W-1:0] arr_word,
   input  logic              arr_valid,
   input  logic              arr_dirty,
   input  logic [TAG_W-1:0]  arr_tag,
   input  logic [31:0]       arr_rdata,
   output logic              arr_inval,
   output logic              mem_wen,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
`ifdef DCACHE_FLUSH_PERF_EN
   output logic [15:0]       wb_count,
`endif
   input  logic              mem_busy
);

   flush_state_t      state_q;
   flush_op_t         op_q;
   logic [TAG_W-1:0]  tag_q;
   logic              mem_wen_q;
   logic [31:0]       mem_addr_q;
   logic [31:0]       wdata_q;
   logic              wb_first_q;
   logic              arr_inval_q;

   logic              walk_start;
   logic              last_frame;
   logic              last_word;
   logic              word_accept;
   logic [SET_W-1:0]  set_w;
   logic [WAY_W-1:0]  way_w;
   logic [WORD_W-1:0] word_w;

   assign walk_start  = (state_q == ST_IDLE) && (dcache_flush || dcache_clear);
   assign word_accept = (state_q == ST_WB_WAIT) && !mem_busy;

   flush_frame_walker #(
      .NSETS           (NSETS),
      .NWAYS           (NWAYS),
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
      .SET_W           (SET_W),
      .WAY_W           (WAY_W),
      .WORD_W          (WORD_W)
   ) u_walker (
      .CLK          (CLK),
      .nRST         (nRST),
      .start_i      (walk_start),
      .frame_adv_i  (state_q == ST_INVAL),
      .word_clr_i   (state_q == ST_READ_TAG),
      .word_adv_i   (word_accept && !last_word),
      .set_o        (set_w),
      .way_o        (way_w),
      .word_o       (word_w),
      .last_frame_o (last_frame),
      .last_word_o  (last_word)
   );

   assign arr_set     = set_w;
   assign arr_way     = way_w;
   assign arr_word    = word_w;
   assign arr_inval   = arr_inval_q;
   assign mem_wen     = mem_wen_q;
   assign mem_addr    = mem_addr_q;
   // Array data arrives in the first WB_WAIT cycle; afterwards the captured copy is held.
   assign mem_wdata   = !mem_wen_q ? '0 : (wb_first_q ? arr_rdata : wdata_q);
   assign engine_busy = (state_q != ST_IDLE);
   assign dflush_done = (state_q == ST_DONE) && dcache_flush;
   assign dclear_done = (state_q == ST_DONE) && dcache_clear;

   // Control FSM with registered strobes and write-port outputs.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_CLEAR;
         tag_q       <= '0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         wdata_q     <= '0;
         wb_first_q  <= 1'b0;
         arr_inval_q <= 1'b0;
      end else begin
         arr_inval_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (dcache_flush || dcache_clear) begin
                  op_q    <= dcache_flush ? OP_FLUSH : OP_CLEAR;
                  state_q <= ST_READ_TAG;
               end
            end
            ST_READ_TAG: state_q <= ST_CHECK;
            ST_CHECK: begin
               tag_q <= arr_tag;
               if (op_q == OP_FLUSH && arr_valid && arr_dirty) begin
                  state_q <= ST_WB_REQ;
               end else begin
                  state_q     <= ST_INVAL;
                  arr_inval_q <= 1'b1;
               end
            end
            ST_WB_REQ: begin
               state_q    <= ST_WB_WAIT;
               mem_wen_q  <= 1'b1;
               wb_first_q <= 1'b1;
               mem_addr_q <= pack_addr(32'(tag_q), 32'(set_w), 32'(word_w), SET_W, WORD_LOG);
            end
            ST_WB_WAIT: begin
               wb_first_q <= 1'b0;
               if (wb_first_q) wdata_q <= arr_rdata;
               if (!mem_busy) begin
                  mem_wen_q <= 1'b0;
                  if (last_word) begin
                     state_q     <= ST_INVAL;
                     arr_inval_q <= 1'b1;
                  end else begin
                     state_q <= ST_WB_REQ;
                  end
               end
            end
            ST_INVAL: state_q <= last_frame ? ST_DONE : ST_READ_TAG;
            ST_DONE: begin
               if (!dcache_flush && !dcache_clear) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef DCACHE_FLUSH_PERF_EN
   logic [15:0] wb_count_q;

   // Words accepted by memory since the current operation left IDLE; saturating.
   always_ff @(posedge CLK) begin
      if (!nRST || walk_start) begin
         wb_count_q <= '0;
      end else if (mem_wen_q && !mem_busy && wb_count_q != 16'hFFFF) begin
         wb_count_q <= wb_count_q + 16'd1;
      end
   end

   assign wb_count = wb_count_q;
`endif

endmodule
